// File: rtl/interp2_fir_pkg.sv
// Shared constants, sequencer states and the polyphase tap-pair table for the
// interpolate-by-2 FIR.
package interp_pkg;

  localparam int DATA_W  = 18;
  localparam int COEF_W  = 16;
  localparam int PROD_W  = 36;
  localparam int ACC_W   = 40;
  localparam int OUT_LSB = 16;

  localparam logic [DATA_W-1:0] SAT_POS = 18'h1FFFF;
  localparam logic [DATA_W-1:0] SAT_NEG = 18'h20001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC_EVEN,
    ST_MAC_ODD,
    ST_DUMP_ODD
  } state_t;

  typedef struct packed {
    logic [2:0] tap_a;
    logic [2:0] tap_b;
    logic       single;
    logic [2:0] coef;
  } tap_sel_t;

  // Even phase pairs x(i) with x(7-i) on c(2i); odd phase pairs x(i) with
  // x(6-i) on c(2i+1), where the centre tap x3 stands alone.
  function automatic tap_sel_t tap_select(input logic odd, input logic [1:0] idx);
    tap_sel_t s;
    s.tap_a  = {1'b0, idx};
    s.tap_b  = odd ? 3'd6 - {1'b0, idx} : 3'd7 - {1'b0, idx};
    s.single = odd && (idx == 2'd3);
    s.coef   = {idx, odd};
    return s;
  endfunction

endpackage

// File: rtl/interp2_fir_if.sv
// Sample stream between the producer and the interpolator: input strobe and
// sample in, filtered sample, its strobe and the sticky overrun flag out.
interface interp2_fir_if;
  import interp_pkg::*;

  logic                     syncIn;
  logic signed [DATA_W-1:0] in;
  logic signed [DATA_W-1:0] out;
  logic                     syncOut;
  logic                     overrun;

  modport master (output syncIn, in, input out, syncOut, overrun);
  modport slave  (input syncIn, in, output out, syncOut, overrun);

endinterface

// File: rtl/interp2_fir_mpy.sv
// Registered 18x18 signed multiplier with clock enable, one clock of latency.
module mpy18x18WithCe
  import interp_pkg::*;
(
  input  logic                     clk,
  input  logic                     ce,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [PROD_W-1:0] p
);

  always_ff @(posedge clk) begin
    if (ce) p <= PROD_W'(a) * PROD_W'(b);
  end

endmodule

// File: rtl/interp2_fir.sv
// Symmetric 15-tap interpolate-by-2 polyphase FIR: one accepted sample yields
// an even and an odd output, both computed on a single shared multiplier.
module interp2_fir
  import interp_pkg::*;
(
  input logic                     clk,
  input logic                     reset,
  interp2_fir_if.slave            bus,
  input logic signed [COEF_W-1:0] c0c14,
  input logic signed [COEF_W-1:0] c1c13,
  input logic signed [COEF_W-1:0] c2c12,
  input logic signed [COEF_W-1:0] c3c11,
  input logic signed [COEF_W-1:0] c4c10,
  input logic signed [COEF_W-1:0] c5c9,
  input logic signed [COEF_W-1:0] c6c8,
  input logic signed [COEF_W-1:0] c7
);

  state_t                   state, state_nxt;
  logic [1:0]               cnt;
  logic                     issue, odd, accept, drop;
  logic                     vld_p1, first_p1, last_p1;
  logic signed [DATA_W-1:0] x [8];
  logic signed [COEF_W-1:0] coef [8];
  tap_sel_t                 sel;
  logic signed [DATA_W-1:0] partner_p0;
  logic signed [DATA_W:0]   pre_sum_p0;
  logic signed [DATA_W-1:0] mul_a_p0, mul_b_p0;
  logic signed [PROD_W-1:0] prod_p1;
  logic signed [ACC_W-1:0]  acc, prod_ext_p1, acc_sum_p1;
  logic [DATA_W-1:0]        out_q;
  logic                     sync_q, ovr_q;

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-OUT_LSB-DATA_W:0] head;
    head = v[ACC_W-1:OUT_LSB+DATA_W-1];
    if (head == '0 || head == '1) return DATA_W'(v >>> OUT_LSB);
    return v[ACC_W-1] ? SAT_NEG : SAT_POS;
  endfunction

  always_comb begin
    coef[0] = c0c14;
    coef[1] = c1c13;
    coef[2] = c2c12;
    coef[3] = c3c11;
    coef[4] = c4c10;
    coef[5] = c5c9;
    coef[6] = c6c8;
    coef[7] = c7;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The even-phase dump overlaps the first odd-phase issue, so the pair of
  // outputs needs only one drain cycle after the last odd issue.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (bus.syncIn) state_nxt = ST_MAC_EVEN;
      ST_MAC_EVEN: if (cnt == 2'd3) state_nxt = ST_MAC_ODD;
      ST_MAC_ODD:  if (cnt == 2'd3) state_nxt = ST_DUMP_ODD;
      ST_DUMP_ODD: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue  = (state == ST_MAC_EVEN) || (state == ST_MAC_ODD);
    odd    = (state == ST_MAC_ODD);
    accept = (state == ST_IDLE) && bus.syncIn;
    drop   = (state != ST_IDLE) && bus.syncIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= 2'd0;
    else if (issue) cnt <= cnt + 2'd1;
    else            cnt <= 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) x[i] <= '0;
    end else if (accept) begin
      x[0] <= bus.in;
      for (int k = 1; k < 8; k++) x[k] <= x[k-1];
    end
  end

  // Stage p0: tap-pair select, pre-add and operand formatting
  always_comb begin
    sel        = tap_select(odd, cnt);
    partner_p0 = sel.single ? '0 : x[sel.tap_b];
    pre_sum_p0 = (DATA_W+1)'(x[sel.tap_a]) + (DATA_W+1)'(partner_p0);
    mul_a_p0   = DATA_W'(pre_sum_p0 >>> 1);
    mul_b_p0   = {coef[sel.coef], 2'b00};
  end

  mpy18x18WithCe u_mpy (
    .clk (clk),
    .ce  (1'b1),
    .a   (mul_a_p0),
    .b   (mul_b_p0),
    .p   (prod_p1)
  );

  // Stage p1: product available; accumulate, and on the last tap of a phase
  // register the saturated result together with its strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      vld_p1   <= issue;
      first_p1 <= (cnt == 2'd0);
      last_p1  <= (cnt == 2'd3);
    end
  end

  always_comb begin
    prod_ext_p1 = ACC_W'(prod_p1);
    acc_sum_p1  = first_p1 ? prod_ext_p1 : acc + prod_ext_p1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      out_q  <= '0;
      sync_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      sync_q <= vld_p1 && last_p1;
      if (vld_p1) acc <= acc_sum_p1;
      if (vld_p1 && last_p1) out_q <= saturate(acc_sum_p1);
      if (drop) ovr_q <= 1'b1;
    end
  end

  assign bus.out     = out_q;
  assign bus.syncOut = sync_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_interp2_fir.sv
// Scoreboard bench for interp2_fir: the driver queues expected outputs with
// their due cycle, the monitor checks every syncOut against the queue head.
module tb_interp2_fir;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  interp2_fir_if bus();
  logic signed [15:0] c [8];

  interp2_fir dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .c0c14 (c[0]),
    .c1c13 (c[1]),
    .c2c12 (c[2]),
    .c3c11 (c[3]),
    .c4c10 (c[4]),
    .c5c9  (c[5]),
    .c6c8  (c[6]),
    .c7    (c[7])
  );

  typedef struct {
    logic [17:0] val;
    int          at;
    string       tag;
  } exp_t;

  exp_t        sb [$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          p0;
  logic [17:0] out_u;

  assign out_u = bus.out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.syncOut) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_syncout: out=%h at cycle %0d, none expected", out_u, cyc);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_val"}, {14'd0, out_u}, {14'd0, e.val});
        chk({e.tag, "_cyc"}, cyc, e.at);
      end
    end
  end

  task automatic strobe(input logic [17:0] v, input bit push, input logic [17:0] ev,
                        input logic [17:0] od, input string tag);
    @(negedge clk);
    bus.syncIn = 1'b1;
    bus.in     = v;
    if (push) begin
      sb.push_back('{ev, cyc + 6, {tag, "_even"}});
      sb.push_back('{od, cyc + 10, {tag, "_odd"}});
    end
    @(negedge clk);
    bus.syncIn = 1'b0;
    bus.in     = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d outputs still pending, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic clear_coefs();
    for (int i = 0; i < 8; i++) c[i] = '0;
  endtask

  // Impulse on strobe 0, zeros on strobes 1..9, spacing 12.
  task automatic impulse_run(input string tag, input int e0, input int e1,
                             input int o0, input int o1);
    for (int k = 0; k < 10; k++) begin
      strobe((k == 0) ? 18'h10000 : 18'h00000, 1'b1,
             (k == e0 || k == e1) ? 18'h08000 : 18'h00000,
             (k == o0 || k == o1) ? 18'h08000 : 18'h00000,
             $sformatf("%s_s%0d", tag, k));
      idle(10);
    end
    drain(tag);
  endtask

  // Constant input at minimum spacing 10; strobe 0 sees only x0 loaded.
  task automatic sat_run(input string tag, input logic [17:0] v,
                         input logic [17:0] first_v, input logic [17:0] rest_v);
    for (int k = 0; k < 10; k++) begin
      strobe(v, 1'b1, (k == 0) ? first_v : rest_v, (k == 0) ? first_v : rest_v,
             $sformatf("%s_s%0d", tag, k));
      idle(8);
    end
    drain(tag);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.syncIn = 1'b0;
    bus.in     = '0;
    clear_coefs();
    @(negedge clk);
    chk("reset_out", {14'd0, out_u}, 32'd0);
    chk("reset_syncout", {31'd0, bus.syncOut}, 32'd0);
    chk("reset_overrun", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk) reset = 1'b0;

    c[0] = 16'h4000;
    impulse_run("even_imp", 0, 7, -1, -1);

    clear_coefs();
    c[7] = 16'h4000;
    do_reset();
    impulse_run("odd_imp", -1, -1, 3, -1);

    for (int i = 0; i < 8; i++) c[i] = 16'h7FFF;
    do_reset();
    sat_run("sat_pos", 18'h1FFFF, 18'h1FFFA, 18'h1FFFF);
    do_reset();
    sat_run("sat_neg", 18'h20000, 18'h20004, 18'h20001);

    clear_coefs();
    c[2] = 16'h4000;
    do_reset();
    p0 = pulses;
    strobe(18'h10000, 1'b1, 18'h00000, 18'h00000, "ovr_a");
    idle(3);
    strobe(18'h0C000, 1'b0, 18'h00000, 18'h00000, "ovr_drop");
    chk("ovr_flag", {31'd0, bus.overrun}, 32'd1);
    drain("ovr_a");
    idle(3);
    chk("ovr_pulses", pulses - p0, 32'd2);
    strobe(18'h00000, 1'b1, 18'h08000, 18'h00000, "ovr_c");
    drain("ovr_c");
    chk("ovr_sticky", {31'd0, bus.overrun}, 32'd1);

    clear_coefs();
    c[0] = 16'h4000;
    do_reset();
    strobe(18'h10000, 1'b1, 18'h08000, 18'h00000, "sp10_a");
    idle(8);
    strobe(18'h04000, 1'b1, 18'h02000, 18'h00000, "sp10_b");
    drain("sp10");
    chk("sp10_overrun", {31'd0, bus.overrun}, 32'd0);

    c[1] = 16'h4000;
    do_reset();
    strobe(18'h10000, 1'b1, 18'h08000, 18'h08000, "rst_pre");
    idle(3);
    strobe(18'h0C000, 1'b0, 18'h00000, 18'h00000, "rst_drop");
    drain("rst_pre");
    chk("rst_pre_overrun", {31'd0, bus.overrun}, 32'd1);
    chk("rst_pre_out", {14'd0, out_u}, 32'h08000);
    strobe(18'h10000, 1'b0, 18'h00000, 18'h00000, "rst_abort");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_out", {14'd0, out_u}, 32'd0);
    chk("rst_async_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_async_syncout", {31'd0, bus.syncOut}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    p0 = pulses;
    idle(15);
    chk("rst_no_syncout", pulses - p0, 32'd0);
    impulse_run("rst_post", 0, 7, 0, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
